// File: rtl/number_generator_n.sv
// Number source for the binary number game: a free-running COUNT/ALT/LFSR core is sampled by a req/ack handshake.
// Latency: req sampled at edge k -> valid after edge k+1. Backpressure: result is held until ack; req without ack is ignored.
// Optional NUMGEN_NO_REPEAT_EN: GEN retries until the candidate differs from the previously captured value.
module number_generator_n #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100),
    parameter int unsigned      GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    input  logic             ack,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, GEN, PRESENT} state_t;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_ALT   = 2'd1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] core, core_nxt, candidate;
    logic             inv_flag, inv_nxt;
    logic [7:0]       grp_cnt, grp_nxt;
    logic             capture, drop;

    always_comb begin
        core_nxt = core;
        grp_nxt  = grp_cnt;
        inv_nxt  = inv_flag;
        if (seed_load) begin
            core_nxt = seed;
            grp_nxt  = 8'd0;
            inv_nxt  = 1'b0;
            // LFSR modes (2 and 3) must never start from the lockup state
            if (mode[1] && seed == '0)
                core_nxt = WIDTH'(1);
        end else if (enable) begin
            if (mode == MODE_COUNT) begin
                core_nxt = core + WIDTH'(1);
            end else if (mode == MODE_ALT) begin
                core_nxt = core + WIDTH'(1);
                if (grp_cnt == 8'(GROUP - 1)) begin
                    grp_nxt = 8'd0;
                    inv_nxt = ~inv_flag;
                end else begin
                    grp_nxt = grp_cnt + 8'd1;
                end
            end else if (core == '0) begin
                core_nxt = WIDTH'(1);
            end else begin
                core_nxt = core[0] ? ((core >> 1) ^ TAPS) : (core >> 1);
            end
        end
    end

    assign candidate = (mode == MODE_ALT && inv_flag) ? ~core : core;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core     <= WIDTH'(1);
            inv_flag <= 1'b0;
            grp_cnt  <= 8'd0;
        end else begin
            core     <= core_nxt;
            inv_flag <= inv_nxt;
            grp_cnt  <= grp_nxt;
        end
    end

`ifdef NUMGEN_NO_REPEAT_EN
    logic [WIDTH-1:0] last;
    logic             has_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= '0;
            has_prev <= 1'b0;
        end else if (capture) begin
            last     <= candidate;
            has_prev <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req)
                    state_nxt = GEN;
            end
            GEN: begin
`ifdef NUMGEN_NO_REPEAT_EN
                capture = !(has_prev && candidate == last);
`else
                capture = 1'b1;
`endif
                if (capture)
                    state_nxt = PRESENT;
            end
            PRESENT: begin
                if (ack) begin
                    drop      = 1'b1;
                    state_nxt = req ? GEN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            valid  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                result <= candidate;
                valid  <= 1'b1;
            end else if (drop) begin
                valid  <= 1'b0;
            end
        end
    end

    assign busy = (state == GEN);

endmodule
